button_reader: RTL and testbench
================================

# button_reader

Debounced push-button/switch input block for the board-level blinker designs. Each of `INPUT_WIDTH` raw asynchronous board inputs is synchronized, debounced by a consecutive-sample counter and presented as a clean level plus one-cycle press/release event pulses. It sits between the board pins and the pattern/LED control logic, the input-side counterpart to the LED pattern drivers.

## Interface
- `COUNT_WIDTH`, 32: width of debounce and hold counters; must hold `DEBOUNCE_COUNT` and `HOLD_COUNT`.
- `DEBOUNCE_COUNT`, 1_000_000: consecutive differing samples required to accept a change (10 ms at 100 MHz); legal range ≥ 1.
- `HOLD_COUNT`, 100_000_000: cycles a level must stay high before `hold` fires (1 s at 100 MHz); legal range ≥ 1; used only with `BUTTON_HOLD_EN`.
- `INPUT_WIDTH`, 4: number of independent channels.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_in`  in  `INPUT_WIDTH`  raw, asynchronous, active-high board inputs.
- `level`  out  `INPUT_WIDTH`  debounced input state, registered.
- `press`  out  `INPUT_WIDTH`  one-cycle pulse on accepted 0→1 change.
- `release`  out  `INPUT_WIDTH`  one-cycle pulse on accepted 1→0 change.
- `hold`  out  `INPUT_WIDTH`  one-cycle long-press pulse; constant 0 without `BUTTON_HOLD_EN`.

## Operation
- Per channel: two-flop synchronizer on `btn_in[i]` gives sample `s`.
- Per-channel FSM, states `ST_STABLE`, `ST_SETTLE`:
  - `ST_STABLE`: counter = 0. If `s != level`, go `ST_SETTLE`, counter ← 1.
  - `ST_SETTLE`: if `s == level` (bounce), go `ST_STABLE`, counter ← 0, no pulse.
  - `ST_SETTLE`, `s != level`, counter < `DEBOUNCE_COUNT`: counter ← counter + 1.
  - Edge at which the `DEBOUNCE_COUNT`-th consecutive differing sample is seen: `level` ← `s`; `press` (if `s`=1) or `release` (if `s`=0) asserted for that one cycle; go `ST_STABLE`, counter ← 0.
  - `DEBOUNCE_COUNT` = 1: accept on first differing sample, straight from `ST_STABLE`.
- Channels fully independent; simultaneous changes on several channels yield simultaneous pulses.
- `press` and `release` of one channel are never high together; `press` always coincides with `level` going 1.
- Counter compare is unsigned, `COUNT_WIDTH` bits; no wrap since counter never exceeds `DEBOUNCE_COUNT`.
- Reset (asynchronous, any time): synchronizers, `level`, `press`, `release`, `hold`, counters all 0, FSM `ST_STABLE`. Reset mid-settle aborts with no pulse. An input held high through reset is re-debounced after release of `rst` and produces `press`.

## Timing
- Reset values: all outputs 0.
- Latency: `btn_in` change captured at edge 0 → `s` changes after edge 1 → `level`/`press`/`release` change after edge `DEBOUNCE_COUNT` + 1.
- Any single-cycle return of `s` to `level` restarts the full `DEBOUNCE_COUNT` count.
- Pulses last exactly one `clk` cycle; minimum spacing between events on one channel is `DEBOUNCE_COUNT` cycles.

## Configuration
- `BUTTON_HOLD_EN` defined: per-channel hold counter counts cycles while `level` = 1, starting at 0 on the `press` edge; `hold` pulses one cycle at the edge where `level` has been 1 for `HOLD_COUNT` cycles; counter then saturates (one `hold` per press); cleared on `release` and reset.
- Not defined: no hold counters instantiated; `hold` tied to 0; `HOLD_COUNT` ignored.

## Structure
- `button_reader_pkg`: state enum typedef (`ST_STABLE`, `ST_SETTLE`), default constants for `DEBOUNCE_COUNT` and `HOLD_COUNT`.
- Sub-module `button_debounce_ch`: one channel (synchronizer, FSM, counters, pulse logic); top generates `INPUT_WIDTH` instances and concatenates outputs.

## Test plan
Bench uses `DEBOUNCE_COUNT`=4, `HOLD_COUNT`=10, `INPUT_WIDTH`=4.
- Reset: assert `rst` with `btn_in`=4'hF → all outputs 0 immediately; release → `level`=4'hF and `press`=4'hF one cycle, 5 edges after release.
- Clean press on ch0 at edge 0 → `level[0]`=1 and `press[0]` one cycle after edge 5; release likewise → `release[0]` one cycle.
- Bounce: `btn_in[0]` high 3 cycles, low 1, high 3, low → no `press`, `level[0]` stays 0.
- Simultaneous: `btn_in` 4'h0→4'h5 → `press`=4'h5 single cycle; then 4'h5→4'hA → `release`=4'h5 and `press`=4'hA on the same cycle.
- Reset mid-settle: `btn_in[1]` high, `rst` pulsed after 2 edges → no pulse during settle; `press[1]` 5 edges after `rst` drops.
- With `BUTTON_HOLD_EN`: hold ch2 high 30 cycles → `hold[2]` exactly once, 10 cycles after `press[2]`; without macro → `hold` always 0.

Source files
------------

// File: rtl/button_reader_pkg.sv
// button_reader_pkg: shared types and default constants for the debounced
// button reader and its per-channel debounce slice.
package button_reader_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic {
        ST_STABLE = 1'b0,   // level agrees with the synchronized sample
        ST_SETTLE = 1'b1    // sample differs, counting consecutive differences
    } deb_state_t;

    // Defaults sized for a 100 MHz system clock.
    localparam int DEF_COUNT_WIDTH    = 32;
    localparam int DEF_DEBOUNCE_COUNT = 1_000_000;     // 10 ms
    localparam int DEF_HOLD_COUNT     = 100_000_000;   // 1 s
    localparam int DEF_INPUT_WIDTH    = 4;

endpackage

// File: rtl/button_debounce_ch.sv
// button_debounce_ch: one debounced input channel.
// Two-flop synchronizer, consecutive-sample debounce FSM, registered level
// and one-cycle press/release pulses. With BUTTON_HOLD_EN defined, a hold
// counter also produces a single long-press pulse per press.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_STABLE | sample equals level, counter idle at 0
// ST_SETTLE | sample differs from level, counter = consecutive differing samples
module button_debounce_ch
    import button_reader_pkg::*;
#(
    parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH,
    parameter int DEBOUNCE_COUNT = DEF_DEBOUNCE_COUNT,
    parameter int HOLD_COUNT     = DEF_HOLD_COUNT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic press,
    output logic release_evt,
    output logic hold
);

    localparam logic [COUNT_WIDTH-1:0] DEB_LAST = COUNT_WIDTH'(DEBOUNCE_COUNT - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam bit                     DEB_ONE  = (DEBOUNCE_COUNT == 1);

    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    deb_state_t             state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sample;
    logic                   accept;

    assign sample = sync2_q;

    // Synchronizer next-state: shift the raw pin through two stages.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
    end

    // Synchronizer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Debounce FSM next-state; accept fires on the DEBOUNCE_COUNT-th differing sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sample != level_q) begin
                    if (DEB_ONE) begin
                        accept = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (sample == level_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            level_d   = sample;
            press_d   = sample;
            release_d = ~sample;
            state_d   = ST_STABLE;
            cnt_d     = '0;
        end
    end

    // Debounce FSM state, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_STABLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level       = level_q;
    assign press       = press_q;
    assign release_evt = release_q;

`ifdef BUTTON_HOLD_EN
    localparam logic [COUNT_WIDTH-1:0] HOLD_LAST = COUNT_WIDTH'(HOLD_COUNT - 1);
    localparam logic [COUNT_WIDTH-1:0] HOLD_MAX  = COUNT_WIDTH'(HOLD_COUNT);

    logic [COUNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic                   hold_q, hold_d;

    // Hold counter next-state: counts high cycles since press, saturates at HOLD_COUNT.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        hold_d     = 1'b0;
        if (!level_q || release_d) begin
            // Counter sits at 0 while low, so it starts from 0 on the press edge.
            hold_cnt_d = '0;
        end else if (hold_cnt_q < HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
            hold_d     = (hold_cnt_q == HOLD_LAST);
        end
    end

    // Hold counter and registered hold pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
            hold_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            hold_q     <= hold_d;
        end
    end

    assign hold = hold_q;
`else
    assign hold = 1'b0;
`endif

endmodule

// File: rtl/button_reader.sv
// button_reader: INPUT_WIDTH independent debounced push-button channels.
// Optional long-press detection is enabled by defining BUTTON_HOLD_EN;
// without it the hold output is constant 0 and HOLD_COUNT is ignored.
// The release pulse port is named release_evt because "release" is a
// reserved SystemVerilog keyword.
module button_reader
    import button_reader_pkg::*;
#(
    parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH,
    parameter int DEBOUNCE_COUNT = DEF_DEBOUNCE_COUNT,
    parameter int HOLD_COUNT     = DEF_HOLD_COUNT,
    parameter int INPUT_WIDTH    = DEF_INPUT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] btn_in,
    output logic [INPUT_WIDTH-1:0] level,
    output logic [INPUT_WIDTH-1:0] press,
    output logic [INPUT_WIDTH-1:0] release_evt,
    output logic [INPUT_WIDTH-1:0] hold
);

    // One independent debounce slice per input pin.
    for (genvar i = 0; i < INPUT_WIDTH; i++) begin : g_ch
        button_debounce_ch #(
            .COUNT_WIDTH   (COUNT_WIDTH),
            .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
            .HOLD_COUNT    (HOLD_COUNT)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_in     (btn_in[i]),
            .level      (level[i]),
            .press      (press[i]),
            .release_evt(release_evt[i]),
            .hold       (hold[i])
        );
    end

endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: directed, table-driven bench for button_reader with
// DEBOUNCE_COUNT=4, HOLD_COUNT=10, INPUT_WIDTH=4. Define BUTTON_HOLD_EN to
// exercise the long-press path.
module tb_button_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_in;
    logic [3:0] level, press, release_evt, hold;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] lev;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    vec_t vecs[$];

    button_reader #(
        .COUNT_WIDTH   (32),
        .DEBOUNCE_COUNT(4),
        .HOLD_COUNT    (10),
        .INPUT_WIDTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .level      (level),
        .press      (press),
        .release_evt(release_evt),
        .hold       (hold)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic [3:0] b, input logic [3:0] l, input logic [3:0] p,
                       input logic [3:0] r, input int n);
        vec_t v;
        v.btn = b; v.lev = l; v.prs = p; v.rel = r;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    int hold_hits;
    int hold_at;
    int found;
    int exp_hold_hits;

    initial begin
        // Vector i: btn applied before edge i, outputs sampled just after it.
        // A change applied at edge e shows on level/press/release after edge e+5.
        add(4'h0, 4'hF, 4'h0, 4'h0, 5);   // release all after reset press
        add(4'h0, 4'h0, 4'h0, 4'hF, 1);
        add(4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(4'h1, 4'h0, 4'h0, 4'h0, 5);   // clean press ch0
        add(4'h1, 4'h1, 4'h1, 4'h0, 1);
        add(4'h1, 4'h1, 4'h0, 4'h0, 1);
        add(4'h0, 4'h1, 4'h0, 4'h0, 5);   // clean release ch0
        add(4'h0, 4'h0, 4'h0, 4'h1, 1);
        add(4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(4'h5, 4'h0, 4'h0, 4'h0, 5);   // simultaneous press 5
        add(4'h5, 4'h5, 4'h5, 4'h0, 1);
        add(4'hA, 4'h5, 4'h0, 4'h0, 5);   // 5 -> A swap
        add(4'hA, 4'hA, 4'hA, 4'h5, 1);
        add(4'hA, 4'hA, 4'h0, 4'h0, 1);
        add(4'h0, 4'hA, 4'h0, 4'h0, 5);   // release A
        add(4'h0, 4'h0, 4'h0, 4'hA, 1);
        add(4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(4'h1, 4'h0, 4'h0, 4'h0, 3);   // bounce: 3 high, 1 low, 3 high, low
        add(4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(4'h1, 4'h0, 4'h0, 4'h0, 3);
        add(4'h0, 4'h0, 4'h0, 4'h0, 6);

        // Reset with all inputs high: everything stays 0.
        rst    = 1'b1;
        btn_in = 4'hF;
        repeat (3) step();
        check("rst_level", level, 4'h0);
        check("rst_press", press, 4'h0);
        check("rst_release", release_evt, 4'h0);
        check("rst_hold", hold, 4'h0);

        // Release reset; edge 0 is the first edge after rst drops.
        rst = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            step();
            check($sformatf("post_rst_level_e%0d", k), level, (k >= 5) ? 4'hF : 4'h0);
            check($sformatf("post_rst_press_e%0d", k), press, (k == 5) ? 4'hF : 4'h0);
        end

        foreach (vecs[i]) begin
            btn_in = vecs[i].btn;
            step();
            check($sformatf("vec%0d_level", i), level, vecs[i].lev);
            check($sformatf("vec%0d_press", i), press, vecs[i].prs);
            check($sformatf("vec%0d_release", i), release_evt, vecs[i].rel);
            check($sformatf("vec%0d_hold", i), hold, 4'h0);
        end

        // Reset mid-settle on ch1: aborted count gives no pulse, then re-debounced.
        btn_in = 4'h2;
        step();
        step();
        check("settle_no_press", press, 4'h0);
        rst = 1'b1;
        step();
        check("settle_rst_level", level, 4'h0);
        rst = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            step();
            check($sformatf("settle_level_e%0d", k), level, (k >= 5) ? 4'h2 : 4'h0);
            check($sformatf("settle_press_e%0d", k), press, (k == 5) ? 4'h2 : 4'h0);
        end

        // Long press on ch2 (ch1 releases at the same time).
        btn_in = 4'h4;
        found  = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (press[2]) found = 1;
        end
        check("hold_press_seen", found, 1);
        check("hold_release_ch1", release_evt, 4'h2);
        hold_hits = 0;
        hold_at   = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (hold[2]) begin
                hold_hits++;
                hold_at = k;
            end
            if ((hold & 4'hB) != 4'h0) check("hold_other_ch", hold, 4'h0);
        end
`ifdef BUTTON_HOLD_EN
        exp_hold_hits = 1;
        check("hold_offset", hold_at, 10);
`else
        exp_hold_hits = 0;
`endif
        check("hold_count", hold_hits, exp_hold_hits);
        check("hold_level", level, 4'h4);

        // Asynchronous reset clears outputs without waiting for a clock edge.
        rst = 1'b1;
        #1;
        check("async_rst_level", level, 4'h0);
        check("async_rst_press", press, 4'h0);
        step();
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
